// File: rtl/bit_grid_mem_if.sv
// Bundle of handshake and cell-access signals for bit_grid_mem.
// Ports (seen from the memory, modport slave):
//   load_start, load_valid, load_row   -> bulk load request and row data
//   load_ready, load_done              <- load handshake and completion pulse
//   dump_start, dump_ready             -> dump request and consumer acceptance
//   dump_valid, dump_row               <- dumped row and its valid flag
//   busy                               <- high while loading or dumping
//   index, wr_en, wr_val, rd_en        -> single-cell access by flat index
//   rd_data, idx_err                   <- registered read data and range error
// The master modport is the controller side with all directions reversed.
interface bit_grid_mem_if #(
  parameter int ROWS = 5,
  parameter int COLS = 5
) ();
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);

  logic             load_start;
  logic             load_valid;
  logic             load_ready;
  logic [COLS-1:0]  load_row;
  logic             load_done;
  logic             dump_start;
  logic             dump_valid;
  logic             dump_ready;
  logic [COLS-1:0]  dump_row;
  logic             busy;
  logic [IDX_W-1:0] index;
  logic             wr_en;
  logic             wr_val;
  logic             rd_en;
  logic             rd_data;
  logic             idx_err;

  modport slave (
    input  load_start, load_valid, load_row, dump_start, dump_ready,
           index, wr_en, wr_val, rd_en,
    output load_ready, load_done, dump_valid, dump_row, busy, rd_data, idx_err
  );

  modport master (
    output load_start, load_valid, load_row, dump_start, dump_ready,
           index, wr_en, wr_val, rd_en,
    input  load_ready, load_done, dump_valid, dump_row, busy, rd_data, idx_err
  );
endinterface

// File: rtl/bit_grid_mem.sv
// ROWS x COLS single-bit cell store for the grid datapath.
// Supports a row-serial bulk load, single-cell read/write by flat index
// (row*COLS+col) and a row-serial dump, both streams using valid/ready.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset; clears every cell and output
//   bus  - bit_grid_mem_if.slave carrying load/dump handshakes and cell ops
// Row data bit c maps to cell r*COLS+c for both load_row and dump_row.
module bit_grid_mem #(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bit_grid_mem_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [CELLS-1:0] grid;

  logic last_row;
  logic in_range;

  // The row counter tops out at ROWS-1; reaching it ends a stream.
  // Grids whose cell count is not a power of two can be addressed past the
  // end, so every cell op checks the index first.
  always_comb begin
    last_row = (row == ROW_W'(ROWS - 1));
    in_range = (int'(bus.index) < CELLS);
  end

  // Single sequential block holding the FSM, the cell array and every
  // registered output. Cell ops are only honoured in IDLE so the streams see
  // a frozen array; the read uses the pre-edge array value, which gives
  // read-before-write when rd_en and wr_en hit the same cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      row            <= '0;
      grid           <= '0;
      bus.load_ready <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_row   <= '0;
      bus.busy       <= 1'b0;
      bus.rd_data    <= 1'b0;
      bus.idx_err    <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      case (state)
        IDLE: begin
          // load_start has priority; a simultaneous dump_start is dropped.
          if (bus.load_start) begin
            state          <= LOAD;
            row            <= '0;
            bus.load_ready <= 1'b1;
            bus.busy       <= 1'b1;
          end else if (bus.dump_start) begin
            state          <= DUMP;
            row            <= '0;
            bus.dump_valid <= 1'b1;
            bus.dump_row   <= grid[0 +: COLS];
            bus.busy       <= 1'b1;
          end
          if (bus.rd_en || bus.wr_en) begin
            if (in_range) begin
              bus.idx_err <= 1'b0;
              if (bus.rd_en) bus.rd_data <= grid[bus.index];
              if (bus.wr_en) grid[bus.index] <= bus.wr_val;
            end else begin
              bus.idx_err <= 1'b1;
              if (bus.rd_en) bus.rd_data <= 1'b0;
            end
          end
        end

        LOAD: begin
          // load_ready is high for the whole of LOAD, so load_valid alone
          // marks an accepted row.
          if (bus.load_valid) begin
            grid[int'(row) * COLS +: COLS] <= bus.load_row;
            if (last_row) begin
              state          <= IDLE;
              row            <= '0;
              bus.load_ready <= 1'b0;
              bus.busy       <= 1'b0;
              bus.load_done  <= 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end
        end

        DUMP: begin
          // dump_row only moves on an accepted transfer, so it stays stable
          // across consumer stalls.
          if (bus.dump_ready) begin
            if (last_row) begin
              state          <= IDLE;
              row            <= '0;
              bus.dump_valid <= 1'b0;
              bus.busy       <= 1'b0;
            end else begin
              row          <= row + 1'b1;
              bus.dump_row <= grid[(int'(row) + 1) * COLS +: COLS];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_grid_mem.sv
// Directed self-checking bench for bit_grid_mem.
// A 5x5 instance covers reset, bulk load, cell access, dump and start
// arbitration; a 3x3 instance covers out-of-range flat indices.
module tb_bit_grid_mem;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   fails = 0;
  int   total = 0;

  int   accepts;
  int   done_cnt;
  int   done_cyc;
  int   ri;
  logic [4:0] exp_rows [5];

  bit_grid_mem_if #(.ROWS(5), .COLS(5)) bus5 ();
  bit_grid_mem_if #(.ROWS(3), .COLS(3)) bus3 ();

  bit_grid_mem #(.ROWS(5), .COLS(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  bit_grid_mem #(.ROWS(3), .COLS(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  always #5 clk = ~clk;

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    bus5.load_start = 0; bus5.load_valid = 0; bus5.load_row = '0;
    bus5.dump_start = 0; bus5.dump_ready = 0; bus5.index = '0;
    bus5.wr_en = 0; bus5.wr_val = 0; bus5.rd_en = 0;
    bus3.load_start = 0; bus3.load_valid = 0; bus3.load_row = '0;
    bus3.dump_start = 0; bus3.dump_ready = 0; bus3.index = '0;
    bus3.wr_en = 0; bus3.wr_val = 0; bus3.rd_en = 0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    applyStimulus(2);
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_load_ready", bus5.load_ready, 0);
    checkOutput("rst_load_done", bus5.load_done, 0);
    checkOutput("rst_dump_valid", bus5.dump_valid, 0);
    checkOutput("rst_dump_row", bus5.dump_row, 0);
    checkOutput("rst_busy", bus5.busy, 0);
    checkOutput("rst_rd_data", bus5.rd_data, 0);
    checkOutput("rst_idx_err", bus5.idx_err, 0);
    checkOutput("rst_busy3", bus3.busy, 0);

    $display("[TB] reset in the middle of a dump");
    bus5.dump_start = 1;
    applyStimulus();
    bus5.dump_start = 0;
    checkOutput("t1_dump_valid", bus5.dump_valid, 1);
    checkOutput("t1_busy", bus5.busy, 1);
    bus5.dump_ready = 1;
    applyStimulus(2);
    checkOutput("t1_mid_valid", bus5.dump_valid, 1);
    rst = 1'b1;
    #2;
    checkOutput("t1_rst_valid", bus5.dump_valid, 0);
    checkOutput("t1_rst_busy", bus5.busy, 0);
    checkOutput("t1_rst_row", bus5.dump_row, 0);
    rst = 1'b0;
    bus5.dump_ready = 0;
    bus5.rd_en = 1; bus5.index = 5'd0;
    applyStimulus();
    bus5.rd_en = 0;
    checkOutput("t1_rd0", bus5.rd_data, 0);
    checkOutput("t1_idle_busy", bus5.busy, 0);
    checkOutput("t1_idle_valid", bus5.dump_valid, 0);

    $display("[TB] gapped bulk load");
    bus5.load_start = 1;
    applyStimulus();
    bus5.load_start = 0;
    checkOutput("t2_load_ready", bus5.load_ready, 1);
    accepts = 0; done_cnt = 0; done_cyc = -1;
    bus5.load_row = 5'b10101;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus5.load_valid = (cyc % 2 == 0);
      if (bus5.load_valid && bus5.load_ready) accepts++;
      applyStimulus();
      if (bus5.load_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    bus5.load_valid = 0;
    checkOutput("t2_accepts", accepts, 5);
    checkOutput("t2_done_count", done_cnt, 1);
    checkOutput("t2_done_cycle", done_cyc, 8);
    checkOutput("t2_busy", bus5.busy, 0);
    checkOutput("t2_load_ready", bus5.load_ready, 0);
    bus5.rd_en = 1;
    bus5.index = 5'd0; applyStimulus(); checkOutput("t2_rd0", bus5.rd_data, 1);
    bus5.index = 5'd1; applyStimulus(); checkOutput("t2_rd1", bus5.rd_data, 0);
    bus5.index = 5'd2; applyStimulus(); checkOutput("t2_rd2", bus5.rd_data, 1);
    bus5.rd_en = 0;

    $display("[TB] read-before-write on one cell");
    bus5.wr_en = 1; bus5.wr_val = 0; bus5.index = 5'd12;
    applyStimulus();
    bus5.wr_val = 1; bus5.rd_en = 1;
    applyStimulus();
    checkOutput("t3_rbw_old", bus5.rd_data, 0);
    bus5.wr_en = 0;
    applyStimulus();
    checkOutput("t3_rd12_new", bus5.rd_data, 1);
    bus5.rd_en = 0;
    bus5.wr_en = 1; bus5.wr_val = 0;
    bus5.index = 5'd5; applyStimulus();
    bus5.index = 5'd24; applyStimulus();
    bus5.wr_en = 0;
    checkOutput("t3_rd_hold", bus5.rd_data, 1);

    $display("[TB] dump with stalling consumer");
    exp_rows[0] = 5'b10101;
    exp_rows[1] = 5'b10100;
    exp_rows[2] = 5'b10101;
    exp_rows[3] = 5'b10101;
    exp_rows[4] = 5'b00101;
    bus5.dump_start = 1;
    applyStimulus();
    bus5.dump_start = 0;
    ri = 0;
    for (int k = 0; k < 30; k++) begin
      if (ri == 5) break;
      bus5.dump_ready = (k % 2 == 0);
      checkOutput("t4_dump_valid", bus5.dump_valid, 1);
      checkOutput($sformatf("t4_dump_row%0d", ri), bus5.dump_row, exp_rows[ri]);
      if (bus5.dump_valid && bus5.dump_ready) ri++;
      applyStimulus();
    end
    bus5.dump_ready = 0;
    checkOutput("t4_rows_sent", ri, 5);
    checkOutput("t4_valid_low", bus5.dump_valid, 0);
    checkOutput("t4_busy_low", bus5.busy, 0);

    $display("[TB] simultaneous starts and cell ops during load");
    bus5.load_start = 1; bus5.dump_start = 1;
    applyStimulus();
    bus5.load_start = 0; bus5.dump_start = 0;
    checkOutput("t6_load_ready", bus5.load_ready, 1);
    checkOutput("t6_no_dump", bus5.dump_valid, 0);
    bus5.load_valid = 1; bus5.load_row = 5'b11111;
    applyStimulus();
    bus5.load_valid = 0;
    bus5.wr_en = 1; bus5.wr_val = 0; bus5.index = 5'd0;
    applyStimulus();
    bus5.wr_en = 0;
    bus5.rd_en = 1; bus5.index = 5'd27;
    applyStimulus();
    bus5.rd_en = 0;
    checkOutput("t6_rd_hold", bus5.rd_data, 1);
    checkOutput("t6_err_hold", bus5.idx_err, 0);
    bus5.load_valid = 1;
    applyStimulus(4);
    bus5.load_valid = 0;
    checkOutput("t6_load_done", bus5.load_done, 1);
    bus5.rd_en = 1;
    bus5.index = 5'd0; applyStimulus(); checkOutput("t6_rd0", bus5.rd_data, 1);
    bus5.index = 5'd5; applyStimulus(); checkOutput("t6_rd5", bus5.rd_data, 1);
    bus5.rd_en = 0;

    $display("[TB] out-of-range indices on 3x3 grid");
    bus3.wr_en = 1; bus3.wr_val = 1; bus3.index = 4'd4;
    applyStimulus();
    bus3.wr_en = 0; bus3.rd_en = 1;
    applyStimulus();
    checkOutput("t5_rd4", bus3.rd_data, 1);
    checkOutput("t5_err_clear", bus3.idx_err, 0);
    for (int i = 9; i < 16; i++) begin
      bus3.index = 4'(i);
      applyStimulus();
      checkOutput($sformatf("t5_oor_rd%0d", i), bus3.rd_data, 0);
      checkOutput($sformatf("t5_oor_err%0d", i), bus3.idx_err, 1);
    end
    bus3.rd_en = 0;
    bus3.wr_en = 1; bus3.wr_val = 1; bus3.index = 4'd10;
    applyStimulus();
    bus3.wr_en = 0;
    checkOutput("t5_wr_err", bus3.idx_err, 1);
    bus3.rd_en = 1;
    for (int i = 0; i < 9; i++) begin
      bus3.index = 4'(i);
      applyStimulus();
      checkOutput($sformatf("t5_cell%0d", i), bus3.rd_data, (i == 4) ? 1 : 0);
      if (i == 0) checkOutput("t5_err_cleared", bus3.idx_err, 0);
    end
    bus3.rd_en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
